// File: rtl/srl16_fifo_ctrl.sv
// 16-deep FIFO built on per-bit shift-register storage, with valid/ready on both sides.
// Define SRLFIFO_OREG_EN to add a registered output stage (capacity 17, latency 2).
module srl16_fifo_ctrl #(
   parameter int WIDTH    = 8,
   parameter int AF_LEVEL = 14
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_wr_valid,
   output logic             o_wr_ready,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_rd_valid,
   input  logic             i_rd_ready,
   output logic [3:0]       o_srl_a,
   output logic [4:0]       o_count,
   output logic             o_empty,
   output logic             o_full,
   output logic             o_almost_full
);

   localparam logic [4:0] AF_CNT = 5'(AF_LEVEL);

   logic [WIDTH-1:0] r_taps [16];
   logic [4:0]       r_cnt;
   logic             w_push;
   logic             w_srl_pop;
   logic             w_has_data;
   logic [3:0]       w_srl_a;
   logic [WIDTH-1:0] w_srl_dout;

   assign w_has_data = (r_cnt != 5'd0);
   assign w_srl_a    = w_has_data ? 4'(r_cnt - 5'd1) : 4'd0;
   assign w_srl_dout = r_taps[w_srl_a];

   // No dependency on the read side: a full FIFO refuses a push even while popping.
   assign o_wr_ready = !i_rst && (r_cnt < 5'd16);
   assign w_push     = i_wr_valid & o_wr_ready;

   // Storage has no reset, matching the SRL primitive.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_taps[0] <= i_din;
         for (int i = 1; i < 16; i++) begin
            r_taps[i] <= r_taps[i-1];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= 5'd0;
      end else if (w_push && !w_srl_pop) begin
         r_cnt <= r_cnt + 5'd1;
      end else if (!w_push && w_srl_pop) begin
         r_cnt <= r_cnt - 5'd1;
      end
   end

`ifdef SRLFIFO_OREG_EN
   logic             r_oreg_valid;
   logic [WIDTH-1:0] r_oreg_data;
   logic             w_out_pop;

   assign w_out_pop = i_rd_ready & r_oreg_valid;
   // Refill the output stage from the oldest SRL entry whenever it is free or draining.
   assign w_srl_pop = w_has_data & (!r_oreg_valid | w_out_pop);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_oreg_valid <= 1'b0;
         r_oreg_data  <= '0;
      end else if (w_srl_pop) begin
         r_oreg_valid <= 1'b1;
         r_oreg_data  <= w_srl_dout;
      end else if (w_out_pop) begin
         r_oreg_valid <= 1'b0;
      end
   end

   assign o_rd_valid = r_oreg_valid;
   assign o_dout     = r_oreg_data;
`else
   assign w_srl_pop  = i_rd_ready & w_has_data;
   assign o_rd_valid = w_has_data;
   assign o_dout     = w_srl_dout;
`endif

   assign o_srl_a       = w_srl_a;
   assign o_count       = r_cnt;
   assign o_empty       = (r_cnt == 5'd0);
   assign o_full        = (r_cnt == 5'd16);
   assign o_almost_full = (r_cnt >= AF_CNT);

endmodule

// File: tb/tb_srl16_fifo_ctrl.sv
// Bench for srl16_fifo_ctrl: directed scenarios plus random traffic against a queue model.
module tb_srl16_fifo_ctrl;

   localparam int WIDTH    = 8;
   localparam int AF_LEVEL = 14;

   logic             clk = 1'b0;
   logic             i_rst = 1'b1;
   logic [WIDTH-1:0] i_din = '0;
   logic             i_wr_valid = 1'b0;
   logic             i_rd_ready = 1'b0;
   logic             o_wr_ready;
   logic [WIDTH-1:0] o_dout;
   logic             o_rd_valid;
   logic [3:0]       o_srl_a;
   logic [4:0]       o_count;
   logic             o_empty;
   logic             o_full;
   logic             o_almost_full;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: q holds the shift-register contents, oldest at the front.
   logic [WIDTH-1:0] q [$];
   logic             m_known = 1'b0;
`ifdef SRLFIFO_OREG_EN
   logic             m_ov = 1'b0;
   logic [WIDTH-1:0] m_od = '0;
`endif

   always #5 clk = ~clk;

   srl16_fifo_ctrl #(.WIDTH(WIDTH), .AF_LEVEL(AF_LEVEL)) dut (
      .i_clk         (clk),
      .i_rst         (i_rst),
      .i_din         (i_din),
      .i_wr_valid    (i_wr_valid),
      .o_wr_ready    (o_wr_ready),
      .o_dout        (o_dout),
      .o_rd_valid    (o_rd_valid),
      .i_rd_ready    (i_rd_ready),
      .o_srl_a       (o_srl_a),
      .o_count       (o_count),
      .o_empty       (o_empty),
      .o_full        (o_full),
      .o_almost_full (o_almost_full)
   );

   task automatic check_val(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      int sz;
      sz = q.size();
      check_val("count",     int'(o_count),       sz);
      check_val("empty",     int'(o_empty),       int'(sz == 0));
      check_val("full",      int'(o_full),        int'(sz == 16));
      check_val("afull",     int'(o_almost_full), int'(sz >= AF_LEVEL));
      check_val("srl_a",     int'(o_srl_a),       (sz > 0) ? sz - 1 : 0);
      check_val("wr_ready",  int'(o_wr_ready),    int'(!i_rst && sz < 16));
`ifdef SRLFIFO_OREG_EN
      check_val("rd_valid",  int'(o_rd_valid),    int'(m_ov));
      check_val("dout",      int'(o_dout),        int'(m_od));
`else
      check_val("rd_valid",  int'(o_rd_valid),    int'(sz != 0));
      if (sz != 0) check_val("dout", int'(o_dout), int'(q[0]));
`endif
   endtask

   // One clock cycle: drive inputs, check the settled outputs, then advance the model.
   task automatic step(input logic rst, input logic wv, input logic [WIDTH-1:0] din,
                       input logic rr);
      logic push;
      logic pop;
      @(negedge clk);
      i_rst      = rst;
      i_wr_valid = wv;
      i_din      = din;
      i_rd_ready = rr;
      #1;
      if (m_known) check_outputs();
      push = wv && !rst && (q.size() < 16);
`ifdef SRLFIFO_OREG_EN
      pop = rr && m_ov;
`else
      pop = rr && (q.size() != 0);
`endif
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_known = 1'b1;
`ifdef SRLFIFO_OREG_EN
         m_ov = 1'b0;
         m_od = '0;
`endif
      end else begin
`ifdef SRLFIFO_OREG_EN
         if (q.size() != 0 && (!m_ov || pop)) begin
            m_od = q.pop_front();
            m_ov = 1'b1;
         end else if (pop) begin
            m_ov = 1'b0;
         end
`else
         if (pop) void'(q.pop_front());
`endif
         if (push) q.push_back(din);
      end
   endtask

   task automatic fill_to(input int level);
      int guard;
      guard = 0;
      while (q.size() < level && guard < 64) begin
         step(1'b0, 1'b1, 8'($urandom), 1'b0);
         guard++;
      end
      check_val("fill_level", q.size(), level);
   endtask

   initial begin
      int pw;
      int pr;
      // Reset, including a cycle with WR_VALID asserted that must be ignored.
      step(1'b1, 1'b0, 8'h00, 1'b0);
      step(1'b1, 1'b1, 8'h55, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);

      // Fill 0x01..0x10 without reading, then offer a 17th word.
      for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
      step(1'b0, 1'b1, 8'h11, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);

      // Drain in order.
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

      // Streaming at occupancy 5.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
`ifdef SRLFIFO_OREG_EN
      step(1'b0, 1'b0, 8'h00, 1'b0);
`endif
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0);

      // Full with simultaneous offer and take: pop only.
      fill_to(16);
      step(1'b0, 1'b1, 8'hEE, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0);

      // Reset at occupancy 7 with a push pending, then 0xAA round trip.
      step(1'b1, 1'b0, 8'h00, 1'b0);
      fill_to(7);
      step(1'b1, 1'b1, 8'h99, 1'b0);
      step(1'b0, 1'b1, 8'hAA, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b1);

      // Random traffic with shifting push/pop bias and rare resets.
      pw = 50;
      pr = 50;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) begin
            pw = int'($urandom_range(10, 95));
            pr = int'($urandom_range(10, 95));
         end
         step($urandom_range(0, 299) == 0,
              int'($urandom_range(0, 99)) < pw,
              8'($urandom),
              int'($urandom_range(0, 99)) < pr);
      end
      step(1'b0, 1'b0, 8'h00, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
